// File: rtl/nano_mem_responder.sv
// rtl/nano_mem_responder.sv - 256x16 memory: power-up clear, loader fill, then CPU serve
// Optional CPU write protection below PROT_TOP is enabled by defining NANO_MEM_WRPROT_EN.
module nano_mem_responder #(
  parameter logic [7:0] PROT_TOP = 8'd15
) (
  input  logic        ck,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [15:0] dataW,
  output logic [15:0] dataR,
  input  logic        ld_valid,
  input  logic [7:0]  ld_addr,
  input  logic [15:0] ld_data,
  output logic        ld_ready,
  input  logic        ld_done,
  output logic        run,
  output logic [15:0] wr_count,
  output logic        wr_err
);

`ifdef NANO_MEM_WRPROT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [15:0] mem [256];
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [15:0] mem_wdata;
  logic        cpu_wr;
  logic        cpu_blocked;

  assign cpu_wr      = (state_q == RUN) && ce && we;
  assign cpu_blocked = PROT_EN && cpu_wr && (address < PROT_TOP);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = address;
    mem_wdata = dataW;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = idx_q;
        mem_wdata = 16'h0000;
        idx_d     = idx_q + 8'd1;
        if (idx_q == 8'hFF) state_d = LOAD;
      end
      LOAD: begin
        // A write arriving together with ld_done still lands on the same edge.
        mem_we    = ld_valid;
        mem_waddr = ld_addr;
        mem_wdata = ld_data;
        if (ld_done) state_d = RUN;
      end
      RUN: begin
        if (cpu_blocked) begin
          err_d = 1'b1;
        end else if (cpu_wr) begin
          mem_we = 1'b1;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR;
      idx_q   <= 8'd0;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Array has no reset; CLEAR defines its contents.
  always_ff @(posedge ck) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign run      = (state_q == RUN);
  assign ld_ready = (state_q == LOAD);
  assign wr_count = cnt_q;
  assign wr_err   = err_q;
  assign dataR    = run ? mem[address] : 16'h0000;

endmodule

// File: tb/tb_nano_mem_responder.sv
// tb/tb_nano_mem_responder.sv - scoreboard bench for nano_mem_responder against a behavioural memory model
// Expectations follow NANO_MEM_WRPROT_EN when defined for the build.
module tb_nano_mem_responder;

`ifdef NANO_MEM_WRPROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif
  localparam int PROT_TOP = 15;

  logic        ck = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0, we = 1'b0;
  logic [7:0]  address = 8'd0;
  logic [15:0] dataW = 16'd0;
  logic [15:0] dataR;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_addr = 8'd0;
  logic [15:0] ld_data = 16'd0;
  logic        ld_ready;
  logic        ld_done = 1'b0;
  logic        run;
  logic [15:0] wr_count;
  logic        wr_err;

  nano_mem_responder dut (
    .ck(ck), .rst(rst), .ce(ce), .we(we), .address(address), .dataW(dataW),
    .dataR(dataR), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_done(ld_done), .run(run), .wr_count(wr_count),
    .wr_err(wr_err)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic [15:0] data;
    logic [15:0] cnt;
    logic        err;
    logic        run;
    logic        rdy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;

  // Reference model: memory image plus the CPU-visible status.
  logic [15:0] m_mem [256];
  logic        m_run;
  logic [15:0] m_cnt;
  logic        m_err;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge ck) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("sb_dataR", dataR, mon_e.data);
      check("sb_wr_count", wr_count, mon_e.cnt);
      check("sb_wr_err", wr_err, mon_e.err);
      check("sb_run", run, mon_e.run);
      check("sb_ld_ready", ld_ready, mon_e.rdy);
    end
  end

  task automatic model_reset();
    m_run = 1'b0;
    m_cnt = 16'd0;
    m_err = 1'b0;
  endtask

  // Releases reset (optionally re-asserting it after abort_at cycles) and waits out CLEAR.
  task automatic clear_phase(input int abort_at);
    rst = 1'b1;
    if (abort_at > 0) begin
      repeat (abort_at) @(posedge ck);
      #3 rst = 1'b0;
      #1;
      check("midclear_ld_ready", ld_ready, 0);
      #2 rst = 1'b1;
    end
    for (int k = 1; k <= 256; k++) begin
      @(posedge ck);
      #1;
      if (k == 255) check("clear_ld_ready_255", ld_ready, 0);
      if (k == 256) check("clear_ld_ready_256", ld_ready, 1);
    end
    check("load_run", run, 0);
    for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;
  endtask

  // All drive tasks start at posedge+1 and return at the next posedge+1.
  task automatic load(input logic v, input logic [7:0] a, input logic [15:0] d, input logic done);
    check("load_ready", ld_ready, 1);
    check("load_dataR_zero", dataR, 0);
    ld_valid = v; ld_addr = a; ld_data = d; ld_done = done;
    if (v) m_mem[a] = d;
    if (done) m_run = 1'b1;
    @(posedge ck);
    #1;
    ld_valid = 1'b0; ld_done = 1'b0;
  endtask

  task automatic cpu_cycle(input logic c, input logic w, input logic [7:0] a, input logic [15:0] d);
    exp_t e;
    ce = c; we = w; address = a; dataW = d;
    ld_valid = 1'($urandom_range(0, 1));
    ld_addr  = 8'($urandom);
    ld_data  = 16'($urandom);
    ld_done  = 1'($urandom_range(0, 1));
    e.data = m_run ? m_mem[a] : 16'h0000;
    e.cnt  = m_cnt;
    e.err  = m_err;
    e.run  = m_run;
    e.rdy  = 1'b0;
    exp_q.push_back(e);
    m_err = 1'b0;
    if (m_run && c && w) begin
      if (PROT && int'(a) < PROT_TOP) begin
        m_err = 1'b1;
      end else begin
        m_mem[a] = d;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
    end
    @(posedge ck);
    #1;
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_run", run, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_dataR", dataR, 0);

    @(negedge ck);
    clear_phase(100);

    for (int i = 0; i < 20; i++)
      load(1'b1, 8'($urandom_range(32, 255)), 16'($urandom), 1'b0);
    load(1'b1, 8'd0, 16'h4000, 1'b0);
    load(1'b1, 8'd30, 16'h000A, 1'b0);
    address = 8'd30;
    load(1'b0, 8'd0, 16'h0000, 1'b1);
    check("ld_done_run", run, 1);

    cpu_cycle(1'b0, 1'b0, 8'd30, 16'h0);
    cpu_cycle(1'b0, 1'b0, 8'd0, 16'h0);
    cpu_cycle(1'b0, 1'b0, 8'd100, 16'h0);
    cpu_cycle(1'b1, 1'b1, 8'd20, 16'h0005);
    cpu_cycle(1'b0, 1'b1, 8'd20, 16'hDEAD);
    cpu_cycle(1'b1, 1'b1, 8'd3, 16'h1234);
    cpu_cycle(1'b0, 1'b0, 8'd3, 16'h0);
    cpu_cycle(1'b1, 1'b1, 8'd14, 16'hAAAA);
    cpu_cycle(1'b1, 1'b1, 8'd15, 16'hBBBB);
    cpu_cycle(1'b0, 1'b0, 8'd14, 16'h0);
    cpu_cycle(1'b0, 1'b0, 8'd15, 16'h0);
    for (int i = 0; i < 300; i++) begin
      cpu_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 31)) : 8'($urandom),
                16'($urandom));
    end
    for (int i = 0; i < 5; i++) cpu_cycle(1'b1, 1'b1, 8'(20 + i), 16'(16'h0100 + i));
    cpu_cycle(1'b0, 1'b0, 8'd20, 16'h0);

    #3 rst = 1'b0;
    model_reset();
    #1;
    check("runrst_run", run, 0);
    check("runrst_wr_count", wr_count, 0);
    check("runrst_wr_err", wr_err, 0);
    check("runrst_dataR", dataR, 0);
    #3;
    clear_phase(0);

    address = 8'd20;
    load(1'b1, 8'd12, 16'hF000, 1'b1);
    check("vd_same_edge_run", run, 1);
    cpu_cycle(1'b0, 1'b0, 8'd12, 16'h0);
    cpu_cycle(1'b0, 1'b0, 8'd20, 16'h0);
    cpu_cycle(1'b0, 1'b0, 8'd30, 16'h0);
    cpu_cycle(1'b0, 1'b0, 8'd0, 16'h0);

    @(negedge ck);
    #1;
    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/nano_mem_responder.md
NANO_MEM_RESPONDER -- requirements
Module: nano_mem_responder

Interface
REQ-001 Parameter PROT_TOP, default 8'd15: first unprotected address; CPU writes below it are blocked when NANO_MEM_WRPROT_EN is defined.
REQ-002 ck  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 ce  in  1  CPU access enable.
REQ-005 we  in  1  CPU write enable, qualified by ce.
REQ-006 address  in  8  CPU word address, 256 x 16-bit space.
REQ-007 dataW  in  16  CPU write data.
REQ-008 dataR  out  16  CPU read data.
REQ-009 ld_valid  in  1  loader write request.
REQ-010 ld_addr  in  8  loader word address.
REQ-011 ld_data  in  16  loader write data.
REQ-012 ld_ready  out  1  loader handshake accept.
REQ-013 ld_done  in  1  loader end-of-program pulse.
REQ-014 run  out  1  memory serving the CPU; CPU held in reset while low.
REQ-015 wr_count  out  16  accepted CPU writes, saturating.
REQ-016 wr_err  out  1  one-cycle pulse on a blocked CPU write.

Function
REQ-017 The FSM SHALL have exactly three states: CLEAR, LOAD and RUN.
- CLEAR -> LOAD after index 255 is written.
- LOAD -> RUN on ld_done=1.
- RUN is terminal until reset.
REQ-018 In CLEAR, an 8-bit index SHALL start at 0 and write 16'h0000 to mem[index] each cycle, for 256 cycles total.
REQ-019 In LOAD, ld_ready SHALL be 1; mem[ld_addr] <= ld_data on each edge with ld_valid=1.
REQ-020 In CLEAR and RUN, ld_ready SHALL be 0 and ld_valid SHALL be ignored.
REQ-021 If ld_valid and ld_done are both 1 in LOAD, the write SHALL complete and the FSM SHALL enter RUN on the same edge.
REQ-022 run SHALL be 1 exactly in state RUN, registered, with no combinational path from inputs.
REQ-023 dataR SHALL be combinational, equal to mem[address] in RUN (zero-latency read) and 16'h0000 otherwise; ce does not gate reads.
REQ-024 In RUN, ce=1 and we=1 SHALL write dataW to mem[address] at the rising edge, visible on dataR the next cycle.
REQ-025 CPU write requests outside RUN SHALL be dropped, with no count and no wr_err.
REQ-026 wr_count SHALL increment by 1 per accepted CPU write and saturate at 16'hFFFF.
REQ-027 A read and a write to the same address in one cycle SHALL return the old data during that cycle.

Reset
REQ-028 rst=0 SHALL asynchronously force state=CLEAR, index=0, wr_count=0, wr_err=0, run=0 and ld_ready=0.
REQ-029 The memory array SHALL have no reset; its contents are defined only after CLEAR completes.
REQ-030 Reset asserted mid-CLEAR, mid-LOAD or in RUN SHALL restart the full 256-cycle CLEAR after release, discarding loaded data.

Configuration
REQ-031 With NANO_MEM_WRPROT_EN defined:
- A RUN-state CPU write with address < PROT_TOP SHALL leave memory unchanged.
- wr_count SHALL NOT increment.
- wr_err SHALL pulse 1 for one cycle.
- Loader writes SHALL never be blocked.
REQ-032 Without NANO_MEM_WRPROT_EN, all RUN-state CPU writes SHALL be accepted and wr_err SHALL be tied to 0.

Verification
REQ-033 Release rst, hold ld_valid=0 -> ld_ready=1 exactly 256 cycles later; a loaded readback of any untouched word = 16'h0000.
REQ-034 Load mem[0]=16'h4000, mem[30]=16'h000A, then pulse ld_done -> run=1 next cycle; address=30 gives dataR=16'h000A.
REQ-035 In RUN, write 16'h0005 to address 20 -> next cycle dataR=16'h0005 and wr_count=1; same-cycle readback shows the old value.
REQ-036 With macro defined, CPU write to address 3 -> mem[3] unchanged, wr_err high for one cycle, wr_count unchanged; without macro -> write lands and wr_err=0.
REQ-037 Assert rst in RUN after 5 writes -> run=0, wr_count=0 immediately; after release, CLEAR repeats and address 20 reads 16'h0000.
REQ-038 In LOAD, drive ld_valid=1 (addr 12, data 16'hF000) together with ld_done=1 -> mem[12]=16'hF000 and run=1 on the following cycle.
